seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver_if.sv | 12 +
 rtl/seg_display_driver.sv | 156 +++++++++++++++
 tb/tb_seg_display_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// Bus between the stopwatch counter stage and the 4-digit 7-segment driver.
// No ready exists: dp_count is a level the driver samples whenever idle, and bcd_valid is a one-cycle strobe.
interface seg_display_driver_if;
  logic [9:0] dp_count;
  logic [3:0] digit_sel;
  logic [6:0] seg;
  logic       bcd_valid;
  logic [1:0] dbg_state;

  modport master (output dp_count, input digit_sel, seg, bcd_valid, dbg_state);
  modport slave  (input dp_count, output digit_sel, seg, bcd_valid, dbg_state);
endinterface

// File: rtl/seg_display_driver.sv
// Binary-to-BCD (double dabble) conversion plus multiplexed 4-digit 7-segment scan.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               hard_reset,
  seg_display_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_e;

  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

  state_e      state_q, state_d;
  logic [9:0]  last_val_q, last_val_d;
  logic [9:0]  bin_q, bin_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  iter_q, iter_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic [19:0] presc_q, presc_d;
  logic [1:0]  scan_q, scan_d;
  logic [15:0] adj;
  logic [3:0]  cur_nib;
  logic        blank;

  always_comb begin
    state_d     = state_q;
    last_val_d  = last_val_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    digits_d    = digits_q;
    iter_d      = iter_q;
    bcd_valid_d = 1'b0;
    adj         = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.dp_count != last_val_q) begin
          last_val_d = bus.dp_count;
          bin_d      = bus.dp_count;
          acc_d      = 16'h0000;
          iter_d     = 4'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        // The extra cycle spent at iter_q == 10 makes capture-to-update exactly 12 edges.
        if (iter_q == 4'd10) begin
          state_d = DONE;
        end else begin
          acc_d  = {adj[14:0], bin_q[9]};
          bin_d  = {bin_q[8:0], 1'b0};
          iter_d = iter_q + 4'd1;
        end
      end
      DONE: begin
        digits_d    = acc_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    presc_d = presc_q + 20'd1;
    scan_d  = scan_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = 20'd0;
      scan_d  = scan_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state_q     <= IDLE;
      last_val_q  <= 10'd0;
      bin_q       <= 10'd0;
      acc_q       <= 16'h0000;
      digits_q    <= 16'h0000;
      iter_q      <= 4'd0;
      bcd_valid_q <= 1'b0;
      presc_q     <= 20'd0;
      scan_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      digits_q    <= digits_d;
      iter_q      <= iter_d;
      bcd_valid_q <= bcd_valid_d;
      presc_q     <= presc_d;
      scan_q      <= scan_d;
    end
  end

  always_comb begin
    case (scan_q)
      2'd0:    cur_nib = digits_q[3:0];
      2'd1:    cur_nib = digits_q[7:4];
      2'd2:    cur_nib = digits_q[11:8];
      default: cur_nib = digits_q[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (scan_q)
      2'd3:    blank = (digits_q[15:12] == 4'd0);
      2'd2:    blank = (digits_q[15:8] == 8'd0);
      2'd1:    blank = (digits_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    case (scan_q)
      2'd0:    bus.digit_sel = 4'b1110;
      2'd1:    bus.digit_sel = 4'b1101;
      2'd2:    bus.digit_sel = 4'b1011;
      default: bus.digit_sel = 4'b0111;
    endcase
  end

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    if (blank) begin
      bus.seg = 7'b1111111;
    end else begin
      case (cur_nib)
        4'd0:    bus.seg = 7'b1000000;
        4'd1:    bus.seg = 7'b1111001;
        4'd2:    bus.seg = 7'b0100100;
        4'd3:    bus.seg = 7'b0110000;
        4'd4:    bus.seg = 7'b0011001;
        4'd5:    bus.seg = 7'b0010010;
        4'd6:    bus.seg = 7'b0000010;
        4'd7:    bus.seg = 7'b1111000;
        4'd8:    bus.seg = 7'b0000000;
        4'd9:    bus.seg = 7'b0010000;
        default: bus.seg = 7'b1111111;
      endcase
    end
  end

  assign bus.bcd_valid = bcd_valid_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver with SCAN_DIV=4; honours LEADING_ZERO_BLANK_EN in its display model.
module tb_seg_display_driver;

  logic clk;
  logic hard_reset;
  seg_display_driver_if bus ();

  seg_display_driver #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  val;
    logic [15:0] exp_bcd;
  } vec_t;

  logic [15:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int idx);
    logic [6:0] s;
    s = dec(bcd[4*idx +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && bcd[15:12] == 4'd0) s = 7'b1111111;
    if (idx == 2 && bcd[15:8] == 8'd0) s = 7'b1111111;
    if (idx == 1 && bcd[15:4] == 12'd0) s = 7'b1111111;
`endif
    return s;
  endfunction

  function automatic int sel_to_idx(input logic [3:0] sel);
    case (sel)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] idx_to_sel(input int idx);
    case (idx)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Counts posedges (starting with the next one) until bcd_valid is seen, capped at 40.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.bcd_valid && n < 40);
  endtask

  task automatic check_current(input string name, input logic [15:0] bcd);
    int idx;
    idx = sel_to_idx(bus.digit_sel);
    check({name, "_sel_legal"}, 32'(idx >= 0), 32'd1);
    if (idx >= 0) check({name, "_seg"}, 32'(bus.seg), 32'(exp_seg(bcd, idx)));
  endtask

  task automatic check_display(input string name, input logic [15:0] bcd);
    repeat (16) begin
      @(posedge clk);
      #1;
      check_current(name, bcd);
    end
  endtask

  task automatic pop_exp(output logic [15:0] e);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_pop: got empty queue expected an entry");
      e = 16'h0000;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic apply(input string name, input logic [9:0] val, input logic [15:0] exp_bcd);
    int n;
    logic [15:0] e;
    bus.dp_count = val;
    exp_q.push_back(exp_bcd);
    wait_pulse(n);
    check({name, "_latency"}, 32'(n - 1), 32'd12);
    pop_exp(e);
    check_current({name, "_update"}, e);
    @(posedge clk);
    #1;
    check({name, "_pulse_width"}, 32'(bus.bcd_valid), 32'd0);
    check_display(name, e);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    logic [15:0] e;
    logic [9:0] last;
    logic [9:0] r;

    vecs[0] = '{val: 10'd999,  exp_bcd: 16'h0999};
    vecs[1] = '{val: 10'd1023, exp_bcd: 16'h1023};
    vecs[2] = '{val: 10'd7,    exp_bcd: 16'h0007};
    vecs[3] = '{val: 10'd500,  exp_bcd: 16'h0500};
    vecs[4] = '{val: 10'd48,   exp_bcd: 16'h0048};
    vecs[5] = '{val: 10'd0,    exp_bcd: 16'h0000};

    // Reset state and scan stepping with no conversion.
    hard_reset   = 1'b1;
    bus.dp_count = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit_sel", 32'(bus.digit_sel), 32'b1110);
    check("rst_seg", 32'(bus.seg), 32'b1000000);
    check("rst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    hard_reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check("scan_sel", 32'(bus.digit_sel), 32'(idx_to_sel((k / 4) % 4)));
      check("scan_seg", 32'(bus.seg), 32'(exp_seg(16'h0000, (k / 4) % 4)));
      check("idle_no_pulse", 32'(bus.bcd_valid), 32'd0);
    end

    for (int i = 0; i < 6; i++) apply("vec", vecs[i].val, vecs[i].exp_bcd);

    // dp_count changes on the third CONV cycle: two conversions back to back.
    bus.dp_count = 10'd5;
    exp_q.push_back(16'h0005);
    repeat (3) @(posedge clk);
    #1;
    bus.dp_count = 10'd6;
    exp_q.push_back(16'h0006);
    wait_pulse(n);
    check("mid_change_first_latency", 32'(n), 32'd10);
    pop_exp(e);
    check_current("mid_change_first", e);
    wait_pulse(n);
    check("mid_change_second_latency", 32'(n), 32'd13);
    pop_exp(e);
    check_current("mid_change_second", e);
    check_display("mid_change_final", e);

    // Reset during CONV aborts; nonzero dp_count restarts right after release.
    bus.dp_count = 10'd900;
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_conv", 32'(bus.dbg_state), 32'd1);
    hard_reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", 32'(bus.dbg_state), 32'd0);
    check("abort_digit_sel", 32'(bus.digit_sel), 32'b1110);
    check("abort_seg", 32'(bus.seg), 32'b1000000);
    check("abort_bcd_valid", 32'(bus.bcd_valid), 32'd0);
    hard_reset = 1'b0;
    exp_q.push_back(16'h0900);
    wait_pulse(n);
    check("post_reset_latency", 32'(n - 1), 32'd12);
    pop_exp(e);
    check_current("post_reset", e);
    check_display("post_reset", e);
    last = 10'd900;

    for (int i = 0; i < 4; i++) begin
      do r = 10'($urandom_range(1023, 0)); while (r == last);
      apply("rand", r, to_bcd(int'(r)));
      last = r;
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
